// File: rtl/sobel_win_pkg.sv
// ---------------------------------------------------------------------------
// sobel_win_pkg
// Shared constants for the sobel window generator:
//   SOBEL_PIX_W / SOBEL_TAP_W : default pixel width and tap width
//                               (taps are one bit wider, MSB forced to 0)
//   S_IDLE / S_ACTIVE / S_DONE: frame FSM state encoding
//   coord_w()                 : width of a column/row counter for a given size
// ---------------------------------------------------------------------------
package sobel_win_pkg;

  localparam int SOBEL_PIX_W = 8;
  localparam int SOBEL_TAP_W = SOBEL_PIX_W + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  // Counter width for a dimension of n entries. Legal sizes start at 3,
  // so this is $clog2(n); the guard only keeps degenerate values sane.
  function automatic int coord_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : sobel_win_pkg

// File: rtl/sobel_line_buf.sv
// ---------------------------------------------------------------------------
// sobel_line_buf
// One image line of delay: DEPTH entries of W bits, indexed by column.
// Read is combinational and returns the entry's old contents in the same
// cycle as a write to that entry (read-before-write), so a buffer read at
// column c yields the pixel from the previous line at column c.
// Ports:
//   clk  : system clock
//   we   : write enable (pixel accepted)
//   addr : column index
//   din  : data written at addr
//   dout : data stored at addr before this cycle's write
// ---------------------------------------------------------------------------
module sobel_line_buf
  import sobel_win_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int W     = 8
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [coord_w(DEPTH)-1:0] addr,
  input  logic [W-1:0]              din,
  output logic [W-1:0]              dout
);

  // NOTE: the storage array has no reset; clearing it would prevent RAM
  // inference, and downstream valid gating already hides stale contents.
  logic [W-1:0] mem_q [DEPTH];

  assign dout = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= din;
    end
  end

endmodule : sobel_line_buf

// File: rtl/sobel_window_gen.sv
// ---------------------------------------------------------------------------
// sobel_window_gen
// Turns a raster-order pixel stream into registered 3x3 neighbourhood taps
// for the sobel gradient stage (centre tap p4 is not needed and omitted).
// Two line buffers supply the two previous lines; three 3-deep column shift
// registers form the window. Taps appear one cycle after the pixel that
// completes them is accepted.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   pix_in, pix_valid  : pixel stream, one pixel per valid cycle
//   sof                : start of frame, qualified by pix_valid
//   p0..p3, p5..p8     : taps {1'b0, pixel}; p8 is the newest pixel
//   win_valid          : taps form a complete interior window
//   frame_done         : one-cycle pulse after the last pixel of a frame
//   win_x, win_y       : window-centre coordinate (only when the macro
//                        SOBEL_WIN_COORD_EN is defined)
// ---------------------------------------------------------------------------
module sobel_window_gen
  import sobel_win_pkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int PIX_W      = SOBEL_PIX_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PIX_W-1:0]              pix_in,
  input  logic                          pix_valid,
  input  logic                          sof,
  output logic [PIX_W:0]                p0,
  output logic [PIX_W:0]                p1,
  output logic [PIX_W:0]                p2,
  output logic [PIX_W:0]                p3,
  output logic [PIX_W:0]                p5,
  output logic [PIX_W:0]                p6,
  output logic [PIX_W:0]                p7,
  output logic [PIX_W:0]                p8,
  output logic                          win_valid,
  output logic                          frame_done
`ifdef SOBEL_WIN_COORD_EN
  ,
  output logic [coord_w(IMG_WIDTH)-1:0]  win_x,
  output logic [coord_w(IMG_HEIGHT)-1:0] win_y
`endif
);

  localparam int CW = coord_w(IMG_WIDTH);
  localparam int RW = coord_w(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;

  logic             accept;
  logic [CW-1:0]    cur_col;
  logic [RW-1:0]    cur_row;
  logic             last_pix;

  logic [PIX_W-1:0] lb_a_dout, lb_b_dout;

  // Column shift registers; index 0 is the left (oldest) column.
  logic [PIX_W-1:0] top_q [3];
  logic [PIX_W-1:0] mid_q [3];
  logic [PIX_W-1:0] bot_q [3];
  logic             win_valid_q;

  // A pixel is taken while a frame is active, or anywhere if it carries
  // sof; sof always forces the pixel to coordinate (0,0).
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // so no path leaves a signal unassigned and no latch is inferred.
    accept   = pix_valid && (sof || (state_q == S_ACTIVE));
    cur_col  = sof ? '0 : col_q;
    cur_row  = sof ? '0 : row_q;
    last_pix = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;

    if (accept) begin
      if (last_pix) begin
        state_d = S_DONE;
        col_d   = '0;
        row_d   = '0;
      end else begin
        state_d = S_ACTIVE;
        if (cur_col == COL_LAST) begin
          col_d = '0;
          row_d = cur_row + RW'(1);
        end else begin
          col_d = cur_col + CW'(1);
          row_d = cur_row;
        end
      end
    end else if (state_q != S_ACTIVE) begin
      // S_DONE lasts one cycle; any unused encoding also falls back to idle.
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  sobel_line_buf #(
    .DEPTH (IMG_WIDTH),
    .W     (PIX_W)
  ) u_lb_a (
    .clk  (clk),
    .we   (accept),
    .addr (cur_col),
    .din  (pix_in),
    .dout (lb_a_dout)
  );

  sobel_line_buf #(
    .DEPTH (IMG_WIDTH),
    .W     (PIX_W)
  ) u_lb_b (
    .clk  (clk),
    .we   (accept),
    .addr (cur_col),
    .din  (lb_a_dout),
    .dout (lb_b_dout)
  );

  // The shift registers are the tap registers: after an accept at (r,c)
  // they hold rows r-2..r, columns c-2..c. Near a line start they still
  // carry columns from the previous line, which win_valid masks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        top_q[i] <= '0;
        mid_q[i] <= '0;
        bot_q[i] <= '0;
      end
      win_valid_q <= 1'b0;
    end else begin
      win_valid_q <= accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      if (accept) begin
        top_q[0] <= top_q[1];
        top_q[1] <= top_q[2];
        top_q[2] <= lb_b_dout;
        mid_q[0] <= mid_q[1];
        mid_q[1] <= mid_q[2];
        mid_q[2] <= lb_a_dout;
        bot_q[0] <= bot_q[1];
        bot_q[1] <= bot_q[2];
        bot_q[2] <= pix_in;
      end
    end
  end

`ifdef SOBEL_WIN_COORD_EN
  logic [CW-1:0] win_x_q;
  logic [RW-1:0] win_y_q;

  // Centre of the window completed by pixel (r,c) is (c-1, r-1); values
  // computed for non-window accepts are never qualified by win_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_x_q <= '0;
      win_y_q <= '0;
    end else if (accept) begin
      win_x_q <= cur_col - CW'(1);
      win_y_q <= cur_row - RW'(1);
    end
  end

  assign win_x = win_x_q;
  assign win_y = win_y_q;
`endif

  assign p0 = {1'b0, top_q[0]};
  assign p1 = {1'b0, top_q[1]};
  assign p2 = {1'b0, top_q[2]};
  assign p3 = {1'b0, mid_q[0]};
  assign p5 = {1'b0, mid_q[2]};
  assign p6 = {1'b0, bot_q[0]};
  assign p7 = {1'b0, bot_q[1]};
  assign p8 = {1'b0, bot_q[2]};

  assign win_valid  = win_valid_q;
  assign frame_done = (state_q == S_DONE);

endmodule : sobel_window_gen

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
Upstream feeder for the sobel gradient stage. It accepts a raster-order 8-bit pixel stream with one pixel per clock when valid. Using two line buffers and a 3x3 shift-register window, it presents the eight neighbour taps p0..p8 (centre p4 omitted) as 9-bit zero-extended values with a window-valid strobe. Taps map directly onto the sobel stage ports, which register internally on the same clk.

Parameters:
IMG_WIDTH, 64, pixels per line; legal range 3..1024.
IMG_HEIGHT, 64, lines per frame; legal range 3..1024.
PIX_W, 8, input pixel width; taps are PIX_W+1 bits with MSB forced to 0.

Ports:
clk  in  1  single system clock, all logic on posedge.
rst_n  in  1  reset; synchronous, active-low.
pix_in  in  PIX_W  incoming pixel.
pix_valid  in  1  pix_in accepted this cycle when high; no backpressure.
sof  in  1  start of frame; qualified by pix_valid; marks pixel (0,0).
p0,p1,p2  out  PIX_W+1  top row: left, centre, right.
p3,p5  out  PIX_W+1  middle row: left, right.
p6,p7,p8  out  PIX_W+1  bottom row: left, centre, right (p8 = newest pixel).
win_valid  out  1  taps form a complete interior window this cycle.
frame_done  out  1  one-cycle pulse after the last pixel of a frame.

Behaviour:
- Reset (rst_n low at posedge): all taps 0, win_valid 0, frame_done 0, col/row counters 0, FSM to S_IDLE. Line-buffer contents are not cleared; win_valid gating masks stale data.
- FSM states and transitions:
  - S_IDLE -> S_ACTIVE on pix_valid&sof. That pixel is accepted as (0,0).
  - In S_IDLE, pix_valid without sof is ignored.
  - S_ACTIVE -> S_DONE on acceptance of (IMG_HEIGHT-1, IMG_WIDTH-1).
  - S_DONE -> S_IDLE unconditionally after 1 cycle. frame_done=1 only in S_DONE.
  - Pixels arriving during S_DONE are dropped unless sof is high; in that case the pixel is accepted as (0,0) and the FSM goes to S_ACTIVE.
- Counters (S_ACTIVE, on each accepted pixel):
  - col increments; it wraps to 0 at IMG_WIDTH-1 and row increments.
  - pix_valid&sof in S_ACTIVE restarts the frame: that pixel is (0,0), counters reload, and no frame_done is issued.
- Line buffers: two IMG_WIDTH x PIX_W delay lines, indexed by col, read-before-write, written only on accept.
  - lb_a writes pix_in and reads pixel (r-1,c).
  - lb_b writes lb_a's read data and reads (r-2,c).
- Window: three 3-deep column shift registers (top from lb_b, middle from lb_a, bottom from pix_in). They shift only on accept.
- Taps are registered. One cycle after accepting pixel (r,c):
  - taps hold rows r-2..r, columns c-2..c;
  - win_valid = (r>=2 && c>=2) for that accepted pixel.
- pix_valid low: taps hold their last value; win_valid 0 next cycle.
- Line-to-line wrap: columns from the previous line sit in the shift registers, but win_valid is 0 for c<2, so no wrap artefacts reach the output.
- Per frame: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) win_valid pulses. Latency from accept to tap is 1 cycle.
- Counter widths are $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT). Taps are {1'b0, pixel}.

Optional Feature:
SOBEL_WIN_COORD_EN:
- Defined: adds outputs win_x [$clog2(IMG_WIDTH)-1:0] and win_y [$clog2(IMG_HEIGHT)-1:0], registered alongside the taps. They give the window-centre coordinate (c-1, r-1), are valid with win_valid, and reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package sobel_win_pkg holds:
  - PIX_W default;
  - TAP_W = PIX_W+1;
  - FSM state encoding (S_IDLE=2'd0, S_ACTIVE=2'd1, S_DONE=2'd2);
  - coordinate width helper functions.
- Sub-module sobel_line_buf (params DEPTH, W; ports clk, we, addr, din, dout; read-before-write) is instantiated twice.

Test Plan:
- IMG_WIDTH=IMG_HEIGHT=4, v(r,c)=10r+c, continuous valid:
  - first win_valid one cycle after accepting (2,2), with p0=0,p1=1,p2=2,p3=10,p5=12,p6=20,p7=21,p8=22;
  - exactly 4 windows; frame_done pulses once, the cycle after accepting (3,3).
- Same frame with pix_valid low for 3 cycles after every pixel: identical tap sequence and 4 windows; taps stable during gaps; win_valid never high in gap cycles.
- Pixels with sof=0 in S_IDLE: no state change, no windows. Then a frame with sof: normal behaviour.
- sof asserted at pixel (2,3) of a frame: counters restart; no window until new (2,2); no frame_done for the aborted frame; the following full frame gives 4 correct windows.
- rst_n low for 1 cycle mid-frame: all outputs 0 next cycle, FSM S_IDLE; the next sof frame is correct.
- With SOBEL_WIN_COORD_EN on the 4x4 frame: (win_x,win_y) sequence (1,1),(2,1),(1,2),(2,2).
